// File: rtl/rheed_ctrl_pkg.sv
// Shared types and helpers for the RHEED inference control blocks.
package rheed_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_CROP = 3'd1,
      S_START     = 3'd2,
      S_RUN       = 3'd3,
      S_OUTPUT    = 3'd4
   } sched_state_t;

   localparam int RESULT_W_DEFAULT = 160;

   // Width of a crop index; kept at one bit minimum so a two-crop frame still has a real select.
   function automatic int CROP_IDX_W(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rheed_watchdog.sv
// Clearable, enabled up-counter that flags a stalled crop.
// The count saturates at its last value so a missed clear cannot wrap into a second pulse.
module rheed_watchdog #(
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // Count enabled cycles since the last clear, holding at the terminal value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != LAST)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // The clear cycle is the first cycle of a new state, so it never reports an expiry.
   assign expired = en && !clr && (cnt == LAST);

endmodule

// File: rtl/rheed_cnn_scheduler.sv
// Frame-level scheduler for the shared RHEED CNN: walks crops in order, runs the
// CNN handshake per crop, collects results into a bank and emits it as one beat.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | no frame open; frame_start opens one
// S_WAIT_CROP | waiting for pending[crop_idx]
// S_START     | cnn_ap_start held until cnn_ap_ready
// S_RUN       | cnn_res_tready high, waiting for the crop result
// S_OUTPUT    | result bank offered downstream, frozen until m_axis_tready
module rheed_cnn_scheduler
   import rheed_ctrl_pkg::*;
#(
   parameter int NUM_CROPS      = 5,
   parameter int RESULT_W       = RESULT_W_DEFAULT,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                frame_start,
   input  logic [NUM_CROPS-1:0]                crop_ready,
   output logic [CROP_IDX_W(NUM_CROPS)-1:0]    crop_idx,
   output logic                                cnn_ap_start,
   input  logic                                cnn_ap_ready,
   input  logic                                cnn_res_tvalid,
   output logic                                cnn_res_tready,
   input  logic [RESULT_W-1:0]                 cnn_res_tdata,
   output logic                                m_axis_tvalid,
   input  logic                                m_axis_tready,
   output logic [NUM_CROPS*RESULT_W-1:0]       m_axis_tdata,
   output logic                                busy,
   output logic                                timeout_err,
   output logic                                frame_drop
);

   localparam int IDX_W = CROP_IDX_W(NUM_CROPS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CROPS - 1);

   sched_state_t                  state;
   logic [NUM_CROPS-1:0]          pending;
   logic [NUM_CROPS*RESULT_W-1:0] bank;
   logic [NUM_CROPS-1:0]          idx_mask;
   logic                          pend_cur;
   logic                          last_crop;
   logic                          wd_clr;
   logic                          wd_en;
   logic                          wd_expired;
   logic                          step;
   logic                          step_tmo;
   logic [RESULT_W-1:0]           step_data;

   assign wd_en        = (state == S_WAIT_CROP) || (state == S_START) || (state == S_RUN);
   assign last_crop    = (crop_idx == LAST_IDX);
   assign pend_cur     = |(pending & idx_mask);
   assign m_axis_tdata = bank;

   rheed_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

   // One-hot of the crop currently routed to the CNN.
   always_comb begin
      idx_mask = '0;
      for (int i = 0; i < NUM_CROPS; i++) begin
         if (crop_idx == IDX_W'(i)) idx_mask[i] = 1'b1;
      end
   end

   // Decide whether this crop finishes now, either with a real result or by watchdog expiry.
   always_comb begin
      step      = 1'b0;
      step_tmo  = 1'b0;
      step_data = '0;
      case (state)
         S_WAIT_CROP: begin
            if (!pend_cur && wd_expired) begin
               step     = 1'b1;
               step_tmo = 1'b1;
            end
         end
         S_START: begin
            if (!cnn_ap_ready && wd_expired) begin
               step     = 1'b1;
               step_tmo = 1'b1;
            end
         end
         S_RUN: begin
            if (cnn_res_tvalid) begin
               step      = 1'b1;
               step_data = cnn_res_tdata;
            end else if (wd_expired) begin
               step     = 1'b1;
               step_tmo = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Sequencer state, registered outputs, pending latch and result bank.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         crop_idx       <= '0;
         cnn_ap_start   <= 1'b0;
         cnn_res_tready <= 1'b0;
         m_axis_tvalid  <= 1'b0;
         busy           <= 1'b0;
         timeout_err    <= 1'b0;
         frame_drop     <= 1'b0;
         pending        <= '0;
         bank           <= '0;
         wd_clr         <= 1'b0;
      end else begin
         frame_drop <= frame_start && (state != S_IDLE);
         wd_clr     <= 1'b0;
         pending    <= pending | crop_ready;

         case (state)
            S_IDLE: begin
               if (frame_start) begin
                  // A ready pulse in the acceptance cycle survives the clear.
                  pending     <= crop_ready;
                  timeout_err <= 1'b0;
                  crop_idx    <= '0;
                  busy        <= 1'b1;
                  wd_clr      <= 1'b1;
                  state       <= S_WAIT_CROP;
               end
            end
            S_WAIT_CROP: begin
               if (pend_cur) begin
                  pending      <= (pending & ~idx_mask) | crop_ready;
                  cnn_ap_start <= 1'b1;
                  wd_clr       <= 1'b1;
                  state        <= S_START;
               end
            end
            S_START: begin
               if (cnn_ap_ready) begin
                  cnn_ap_start   <= 1'b0;
                  cnn_res_tready <= 1'b1;
                  wd_clr         <= 1'b1;
                  state          <= S_RUN;
               end
            end
            S_RUN: ;
            S_OUTPUT: begin
               if (m_axis_tready) begin
                  m_axis_tvalid <= 1'b0;
                  busy          <= 1'b0;
                  crop_idx      <= '0;
                  wd_clr        <= 1'b1;
                  state         <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase

         // Crop completion: a timed-out crop advances exactly like a real result, with zeros.
         if (step) begin
            for (int i = 0; i < NUM_CROPS; i++) begin
               if (idx_mask[i]) bank[i*RESULT_W +: RESULT_W] <= step_data;
            end
            if (step_tmo) timeout_err <= 1'b1;
            cnn_ap_start   <= 1'b0;
            cnn_res_tready <= 1'b0;
            wd_clr         <= 1'b1;
            if (last_crop) begin
               m_axis_tvalid <= 1'b1;
               state         <= S_OUTPUT;
            end else begin
               crop_idx <= crop_idx + IDX_W'(1);
               state    <= S_WAIT_CROP;
            end
         end
      end
   end

endmodule

// File: tb/tb_rheed_cnn_scheduler.sv
// Self-checking bench for rheed_cnn_scheduler: table of frame scenarios, a CNN
// responder model, and a scoreboard of expected result banks.
module tb_rheed_cnn_scheduler;

   localparam int NC  = 5;
   localparam int RW  = 160;
   localparam int TMO = 600;
   localparam int BW  = NC * RW;

   typedef struct {
      string         name;
      logic [RW-1:0] base;
      int            late_crop;
      int            skip_crop;
      int            bp_cycles;
   } vec_t;

   typedef struct {
      logic [BW-1:0] bank;
      logic          tmo;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          frame_start = 1'b0;
   logic [NC-1:0] crop_ready = '0;
   logic [2:0]    crop_idx;
   logic          cnn_ap_start;
   logic          cnn_ap_ready = 1'b0;
   logic          cnn_res_tvalid = 1'b0;
   logic          cnn_res_tready;
   logic [RW-1:0] cnn_res_tdata = '0;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b1;
   logic [BW-1:0] m_axis_tdata;
   logic          busy;
   logic          timeout_err;
   logic          frame_drop;

   int            errors = 0;
   int            checks = 0;
   int            cyc = 0;
   int            beats = 0;
   int            model_epoch = 0;
   int            model_skip = -1;
   logic [RW-1:0] model_base = '0;
   int            last_hs_cyc = 0;
   exp_t          sb[$];
   exp_t          mon_e;
   vec_t          vecs[5];

   rheed_cnn_scheduler #(
      .NUM_CROPS      (NC),
      .RESULT_W       (RW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .frame_start    (frame_start),
      .crop_ready     (crop_ready),
      .crop_idx       (crop_idx),
      .cnn_ap_start   (cnn_ap_start),
      .cnn_ap_ready   (cnn_ap_ready),
      .cnn_res_tvalid (cnn_res_tvalid),
      .cnn_res_tready (cnn_res_tready),
      .cnn_res_tdata  (cnn_res_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tdata   (m_axis_tdata),
      .busy           (busy),
      .timeout_err    (timeout_err),
      .frame_drop     (frame_drop)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_bank(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string n, input logic [RW-1:0] b, input int late,
                               input int skip, input int bp);
      vec_t v;
      v.name      = n;
      v.base      = b;
      v.late_crop = late;
      v.skip_crop = skip;
      v.bp_cycles = bp;
      return v;
   endfunction

   // Scoreboard: every downstream handshake pops one expected bank.
   always @(negedge clk) begin
      if (reset_n && m_axis_tvalid && m_axis_tready) begin
         beats++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got beat %0h expected none", m_axis_tdata);
         end else begin
            mon_e = sb.pop_front();
            chk_bank("beat_data", m_axis_tdata, mon_e.bank);
            chk("beat_timeout_err", int'(timeout_err), int'(mon_e.tmo));
         end
      end
   end

   // CNN model: ap_ready one cycle after ap_start is seen, result 10 cycles after ap_ready.
   initial begin
      int   ep;
      int   idx;
      int   n;
      int   hs_cyc;
      logic hs;
      forever begin
         @(posedge clk); #1;
         if (reset_n && cnn_ap_start) begin
            ep  = model_epoch;
            idx = int'(crop_idx);
            cnn_ap_ready = 1'b1;
            @(posedge clk); #1;
            cnn_ap_ready = 1'b0;
            if (idx != model_skip) begin
               repeat (9) begin @(posedge clk); #1; end
               if (ep == model_epoch) begin
                  cnn_res_tvalid = 1'b1;
                  cnn_res_tdata  = model_base + RW'(idx);
                  n = 0;
                  hs = 1'b0;
                  hs_cyc = 0;
                  while (!hs && n < 200 && ep == model_epoch) begin
                     @(negedge clk);
                     hs = cnn_res_tready;
                     hs_cyc = cyc;
                     @(posedge clk); #1;
                     n++;
                  end
                  cnn_res_tvalid = 1'b0;
                  cnn_res_tdata  = '0;
                  if (ep == model_epoch) begin
                     if (!hs) begin
                        checks++;
                        errors++;
                        $display("FAIL cnn_result_handshake: got no tready for crop %0d expected tready", idx);
                     end else if (idx < NC - 1) begin
                        chk("crop_idx_advance", int'(crop_idx), idx + 1);
                     end else begin
                        last_hs_cyc = hs_cyc;
                     end
                  end
               end
            end
         end
      end
   end

   task automatic run_vec(input vec_t v);
      exp_t          e;
      logic [NC-1:0] mask;
      logic [BW-1:0] held;
      int            n;
      int            bad;
      int            reached;
      e.bank = '0;
      e.tmo  = (v.skip_crop >= 0);
      for (int i = 0; i < NC; i++) begin
         e.bank[i*RW +: RW] = (i == v.skip_crop) ? '0 : v.base + RW'(i);
      end
      sb.push_back(e);
      model_base = v.base;
      model_skip = v.skip_crop;
      mask = '1;
      if (v.late_crop >= 0) mask[v.late_crop] = 1'b0;
      m_axis_tready = (v.bp_cycles == 0);

      @(posedge clk); #1;
      frame_start = 1'b1;
      crop_ready  = mask;
      @(posedge clk); #1;
      frame_start = 1'b0;
      crop_ready  = '0;
      chk({v.name, "_busy_c1"}, int'(busy), 1);
      chk({v.name, "_tmo_cleared_c1"}, int'(timeout_err), 0);
      chk({v.name, "_ap_start_c1"}, int'(cnn_ap_start), 0);
      @(posedge clk); #1;
      chk({v.name, "_ap_start_c2"}, int'(cnn_ap_start), 1);

      if (v.late_crop >= 0) begin
         reached = 0;
         bad = 0;
         for (int c = 3; c < 500; c++) begin
            @(posedge clk); #1;
            if (int'(crop_idx) == v.late_crop) begin
               reached = 1;
               if (cnn_ap_start) bad++;
            end
         end
         chk({v.name, "_reached_wait"}, reached, 1);
         chk({v.name, "_ap_start_held_low"}, bad, 0);
         @(posedge clk); #1;
         crop_ready[v.late_crop] = 1'b1;
         @(posedge clk); #1;
         crop_ready = '0;
         chk({v.name, "_idx_after_pulse"}, int'(crop_idx), v.late_crop);
         chk({v.name, "_ap_start_pulse_p1"}, int'(cnn_ap_start), 0);
         @(posedge clk); #1;
         chk({v.name, "_ap_start_pulse_p2"}, int'(cnn_ap_start), 1);
      end

      n = 0;
      while (!m_axis_tvalid && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!m_axis_tvalid) begin
         checks++;
         errors++;
         $display("FAIL %s_tvalid_wait: got no m_axis_tvalid after %0d cycles expected a beat", v.name, n);
         void'(sb.pop_back());
         return;
      end
      if (v.skip_crop != NC - 1) chk({v.name, "_tvalid_latency"}, cyc, last_hs_cyc + 1);

      if (v.bp_cycles > 0) begin
         held = m_axis_tdata;
         bad = 0;
         for (int k = 0; k < v.bp_cycles; k++) begin
            @(posedge clk); #1;
            if (!m_axis_tvalid || m_axis_tdata !== held) bad++;
            if (k == 10) frame_start = 1'b1;
            if (k == 11) begin
               frame_start = 1'b0;
               chk({v.name, "_drop_in_output"}, int'(frame_drop), 1);
            end
            if (k == 12) chk({v.name, "_drop_one_cycle"}, int'(frame_drop), 0);
         end
         chk({v.name, "_stable_under_bp"}, bad, 0);
         m_axis_tready = 1'b1;
         frame_start   = 1'b1;
         @(posedge clk); #1;
         frame_start = 1'b0;
         chk({v.name, "_drop_at_handshake"}, int'(frame_drop), 1);
         chk({v.name, "_tvalid_after"}, int'(m_axis_tvalid), 0);
         chk({v.name, "_busy_after"}, int'(busy), 0);
         @(posedge clk); #1;
         chk({v.name, "_frame_ignored"}, int'(busy), 0);
      end else begin
         @(posedge clk); #1;
         chk({v.name, "_tvalid_after"}, int'(m_axis_tvalid), 0);
         chk({v.name, "_busy_after"}, int'(busy), 0);
      end
      chk({v.name, "_idx_after"}, int'(crop_idx), 0);
      chk({v.name, "_sb_empty"}, sb.size(), 0);
   endtask

   initial begin
      int n;
      int bad;
      vecs[0] = mk("nominal",      160'hA0, -1, -1, 0);
      vecs[1] = mk("late_crop",    160'hB0,  2, -1, 0);
      vecs[2] = mk("watchdog",     160'hC0, -1,  3, 0);
      vecs[3] = mk("backpressure", 160'hD0, -1, -1, 50);
      vecs[4] = mk("after_reset",  {32'hDEAD_BEEF, 128'h0123_4567_89AB_CDEF_0000_0000_0000_0100}, -1, -1, 0);

      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_crop_idx", int'(crop_idx), 0);
      chk("rst_ap_start", int'(cnn_ap_start), 0);
      chk("rst_res_tready", int'(cnn_res_tready), 0);
      chk("rst_tvalid", int'(m_axis_tvalid), 0);
      chk_bank("rst_tdata", m_axis_tdata, '0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_timeout_err", int'(timeout_err), 0);
      chk("rst_frame_drop", int'(frame_drop), 0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // Reset while crop 1 is in RUN: outputs drop immediately, no beat is produced.
      model_base = 160'hE0;
      model_skip = -1;
      m_axis_tready = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b1;
      crop_ready  = '1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      crop_ready  = '0;
      n = 0;
      while (!(int'(crop_idx) == 1 && cnn_res_tready) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("midrun_reached", int'(int'(crop_idx) == 1 && cnn_res_tready), 1);
      reset_n = 1'b0;
      model_epoch++;
      #1;
      chk("midrun_crop_idx", int'(crop_idx), 0);
      chk("midrun_ap_start", int'(cnn_ap_start), 0);
      chk("midrun_res_tready", int'(cnn_res_tready), 0);
      chk("midrun_busy", int'(busy), 0);
      chk("midrun_tvalid", int'(m_axis_tvalid), 0);
      chk_bank("midrun_tdata", m_axis_tdata, '0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (m_axis_tvalid || busy) bad++;
      end
      chk("midrun_quiet_after", bad, 0);
      n = beats;
      run_vec(vecs[4]);
      chk("after_reset_one_beat", beats - n, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got time %0t expected completion", $time);
      $fatal(1, "simulation time limit");
   end

endmodule
